// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller:
// funct3 load/store width codes, the IO window base and FSM states.
package mem_ctrl_pkg;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IFETCH,
        ST_LOAD,
        ST_STORE,
        ST_DONE
    } state_t;

    // Index of the final byte of an access (byte count minus one).
    function automatic logic [1:0] last_idx(input logic [1:0] width);
        case (width)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// Load extension: widens assembled little-endian bytes to 32 bits
// with sign or zero extension selected by funct3.
module mem_ld_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] bytes,
    input  logic [2:0]  op,
    output logic [31:0] res
);

    always_comb begin
        res = bytes;
        case (op)
            OP_LB:   res = {{24{bytes[7]}}, bytes[7:0]};
            OP_LH:   res = {{16{bytes[15]}}, bytes[15:0]};
            OP_LW:   res = bytes;
            OP_LBU:  res = {24'd0, bytes[7:0]};
            OP_LHU:  res = {16'd0, bytes[15:0]};
            default: res = bytes;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller serving the LSB and instruction fetcher.
// Optional MEM_IO_STALL_EN holds IO-window store bytes while io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        is_io,
    input  logic        is_store,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_data,
    input  logic [2:0]  io_op,
    output logic        mem_res_avail,
    output logic [31:0] mem_res,
    output logic        mem_stuck
);

    state_t      state, state_n;
    logic [1:0]  idx, idx_n, idx_inc, cap, last;
    logic        tail, tail_n;
    logic        kill, kill_n;
    logic        fetch, fetch_n;
    logic        wr, wr_n;
    logic [2:0]  op, op_n;
    logic [31:0] bytes, bytes_n;
    logic [31:0] addr_n, res_n, ifd_n;
    logic [7:0]  dout_n;
    logic [31:0] asm_w, ext;
    logic        stall, done_ok;

    // Read data lags the address by one cycle, so the byte
    // arriving now belongs to the previous index.
    assign idx_inc = idx + 2'd1;
    assign cap     = idx - 2'd1;
    assign last    = last_idx(op[1:0]);

    always_comb begin
        asm_w = bytes;
        asm_w[{cap, 3'b000} +: 8] = mem_din;
    end

    mem_ld_ext u_ext (
        .bytes (asm_w),
        .op    (op),
        .res   (ext)
    );

`ifdef MEM_IO_STALL_EN
    assign stall = (state == ST_STORE) && (mem_a >= IO_BASE)
                   && io_buffer_full;
`else
    logic io_full_unused;
    assign io_full_unused = io_buffer_full;
    assign stall = 1'b0;
`endif

    assign mem_wr    = wr & rdy_in & ~stall;
    assign mem_stuck = (state != ST_IDLE);

    // Pulses are gated live so a flush or freeze during DONE hides them.
    assign done_ok       = (state == ST_DONE) && rdy_in && !rob_clear && !kill;
    assign mem_res_avail = done_ok & ~fetch;
    assign if_ready      = done_ok & fetch;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        tail_n  = tail;
        kill_n  = kill;
        fetch_n = fetch;
        wr_n    = wr;
        op_n    = op;
        bytes_n = bytes;
        addr_n  = mem_a;
        dout_n  = mem_dout;
        res_n   = mem_res;
        ifd_n   = if_data;
        if (rdy_in) begin
            unique case (state)
                ST_IDLE: begin
                    idx_n  = 2'd0;
                    tail_n = 1'b0;
                    kill_n = 1'b0;
                    if (is_io) begin
                        fetch_n = 1'b0;
                        op_n    = io_op;
                        addr_n  = io_addr;
                        if (is_store) begin
                            state_n = ST_STORE;
                            wr_n    = 1'b1;
                            bytes_n = io_data;
                            dout_n  = io_data[7:0];
                        end else begin
                            state_n = ST_LOAD;
                            bytes_n = '0;
                        end
                    end else if (if_req) begin
                        state_n = ST_IFETCH;
                        fetch_n = 1'b1;
                        op_n    = OP_LW;
                        addr_n  = if_addr;
                        bytes_n = '0;
                    end
                end
                ST_LOAD, ST_IFETCH: begin
                    if (rob_clear) begin
                        state_n = ST_IDLE;
                    end else begin
                        if (idx != 2'd0 || tail) begin
                            bytes_n = asm_w;
                        end
                        if (tail) begin
                            state_n = ST_DONE;
                            if (fetch) begin
                                ifd_n = asm_w;
                            end else begin
                                res_n = ext;
                            end
                        end else begin
                            idx_n = idx_inc;
                            if (idx == last) begin
                                tail_n = 1'b1;
                            end else begin
                                addr_n = mem_a + 32'd1;
                            end
                        end
                    end
                end
                ST_STORE: begin
                    if (rob_clear) begin
                        kill_n = 1'b1;
                    end
                    if (!stall) begin
                        if (idx == last) begin
                            state_n = ST_DONE;
                            wr_n    = 1'b0;
                            res_n   = '0;
                        end else begin
                            idx_n  = idx_inc;
                            addr_n = mem_a + 32'd1;
                            dout_n = bytes[{idx_inc, 3'b000} +: 8];
                        end
                    end
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                    kill_n  = 1'b0;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            tail     <= 1'b0;
            kill     <= 1'b0;
            fetch    <= 1'b0;
            wr       <= 1'b0;
            op       <= 3'd0;
            bytes    <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_res  <= '0;
            if_data  <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            tail     <= tail_n;
            kill     <= kill_n;
            fetch    <= fetch_n;
            wr       <= wr_n;
            op       <= op_n;
            bytes    <= bytes_n;
            mem_a    <= addr_n;
            mem_dout <= dout_n;
            mem_res  <= res_n;
            if_data  <= ifd_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a 64 KiB byte RAM model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        rob_clear = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        is_io = 1'b0;
    logic        is_store = 1'b0;
    logic [31:0] io_addr = 32'd0;
    logic [31:0] io_data = 32'd0;
    logic [2:0]  io_op = 3'd0;
    logic        mem_res_avail;
    logic [31:0] mem_res;
    logic        mem_stuck;

    logic [7:0] ram [0:65535];
    int checks = 0;
    int errors = 0;

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear      (rob_clear),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ready       (if_ready),
        .if_data        (if_data),
        .is_io          (is_io),
        .is_store       (is_store),
        .io_addr        (io_addr),
        .io_data        (io_data),
        .io_op          (io_op),
        .mem_res_avail  (mem_res_avail),
        .mem_res        (mem_res),
        .mem_stuck      (mem_stuck)
    );

    always #5 clk_in = ~clk_in;

    // RAM freezes with the rest of the system when rdy_in is low.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            mem_din <= ram[mem_a[15:0]];
            if (mem_wr) ram[mem_a[15:0]] = mem_dout;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr,
                           input logic [2:0] op, input int n,
                           input logic [31:0] exp);
        int cyc;
        is_io = 1'b1;
        is_store = 1'b0;
        io_addr = addr;
        io_op = op;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            chk({tag, " addr"}, mem_a, addr + i);
        end
        cyc = n;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!mem_res_avail && cyc < n + 10);
        chk({tag, " latency"}, cyc, n + 2);
        chk({tag, " result"}, mem_res, exp);
        is_io = 1'b0;
        @(negedge clk_in);
        chk({tag, " idle"}, {30'd0, mem_stuck, mem_res_avail}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr,
                            input logic [2:0] op, input int n,
                            input logic [31:0] data);
        int cyc;
        is_io = 1'b1;
        is_store = 1'b1;
        io_addr = addr;
        io_data = data;
        io_op = op;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            chk({tag, " wr"}, {31'd0, mem_wr}, 32'd1);
            chk({tag, " addr"}, mem_a, addr + i);
            chk({tag, " dout"}, {24'd0, mem_dout}, (data >> (8 * i)) & 32'hFF);
        end
        cyc = n;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!mem_res_avail && cyc < n + 10);
        chk({tag, " latency"}, cyc, n + 1);
        chk({tag, " res zero"}, mem_res, 32'd0);
        chk({tag, " wr off"}, {31'd0, mem_wr}, 32'd0);
        is_io = 1'b0;
        is_store = 1'b0;
        @(negedge clk_in);
        chk({tag, " idle"}, {30'd0, mem_stuck, mem_res_avail}, 32'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h11;
        ram[16'h0101] = 8'h22;
        ram[16'h0102] = 8'h33;
        ram[16'h0103] = 8'h44;
        ram[16'h0080] = 8'h80;
        ram[16'h7FFE] = 8'hFF;
        ram[16'h7FFF] = 8'hFF;
        ram[16'h0000] = 8'h13;
        ram[16'h0001] = 8'h05;

        repeat (2) @(negedge clk_in);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset dout/wr", {23'd0, mem_dout, mem_wr}, 32'd0);
        chk("reset pulses", {29'd0, if_ready, mem_res_avail, mem_stuck}, 32'd0);
        chk("reset if_data", if_data, 32'd0);
        chk("reset mem_res", mem_res, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        do_load("lw 0x100", 32'h100, 3'b010, 4, 32'h4433_2211);
        do_load("lb 0x80", 32'h80, 3'b000, 1, 32'hFFFF_FF80);
        do_load("lbu 0x80", 32'h80, 3'b100, 1, 32'h0000_0080);
        do_load("lhu 0x7FFE", 32'h7FFE, 3'b101, 2, 32'h0000_FFFF);
        do_load("lh 0x7FFE", 32'h7FFE, 3'b001, 2, 32'hFFFF_FFFF);

        do_store("sh 0x200", 32'h200, 3'b001, 2, 32'hAABB_BEEF);
        chk("sh ram lo", {24'd0, ram[16'h0200]}, 32'hEF);
        chk("sh ram hi", {24'd0, ram[16'h0201]}, 32'hBE);
        chk("sh ram untouched", {24'd0, ram[16'h0202]}, 32'h00);

        // Data request wins arbitration; fetch follows once back in IDLE.
        if_req = 1'b1;
        if_addr = 32'h0;
        do_load("arb lw", 32'h100, 3'b010, 4, 32'h4433_2211);
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!if_ready && cyc < 20);
        chk("fetch latency", cyc, 6);
        chk("fetch data", if_data, 32'h0000_0513);
        chk("fetch no avail", {31'd0, mem_res_avail}, 32'd0);
        if_req = 1'b0;
        @(negedge clk_in);
        chk("fetch pulse width", {30'd0, if_ready, mem_stuck}, 32'd0);

        // Flush during a load: abort, no pulse.
        is_io = 1'b1;
        is_store = 1'b0;
        io_addr = 32'h100;
        io_op = 3'b010;
        repeat (3) @(negedge clk_in);
        rob_clear = 1'b1;
        is_io = 1'b0;
        @(negedge clk_in);
        chk("flush load idle", {31'd0, mem_stuck}, 32'd0);
        rob_clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flush load no avail", {31'd0, mem_res_avail}, 32'd0);
            @(negedge clk_in);
        end

        // Flush during a store: writes finish, pulse suppressed.
        is_io = 1'b1;
        is_store = 1'b1;
        io_addr = 32'h300;
        io_data = 32'h0000_1234;
        io_op = 3'b001;
        @(negedge clk_in);
        chk("flush st wr0", {31'd0, mem_wr}, 32'd1);
        rob_clear = 1'b1;
        is_io = 1'b0;
        is_store = 1'b0;
        @(negedge clk_in);
        rob_clear = 1'b0;
        chk("flush st wr1", {31'd0, mem_wr}, 32'd1);
        chk("flush st addr1", mem_a, 32'h301);
        @(negedge clk_in);
        chk("flush st done", {30'd0, mem_stuck, mem_res_avail}, 32'd2);
        @(negedge clk_in);
        chk("flush st idle", {31'd0, mem_stuck}, 32'd0);
        chk("flush st ram", {16'd0, ram[16'h0301], ram[16'h0300]}, 32'h1234);

        // Freeze in the middle of a store byte.
        is_io = 1'b1;
        is_store = 1'b1;
        io_addr = 32'h40;
        io_data = 32'h0000_005A;
        io_op = 3'b000;
        @(negedge clk_in);
        chk("freeze wr before", {31'd0, mem_wr}, 32'd1);
        rdy_in = 1'b0;
        #1;
        chk("freeze wr forced", {31'd0, mem_wr}, 32'd0);
        @(negedge clk_in);
        chk("freeze hold", {30'd0, mem_stuck, mem_res_avail}, 32'd2);
        chk("freeze ram", {24'd0, ram[16'h0040]}, 32'h00);
        rdy_in = 1'b1;
        @(negedge clk_in);
        chk("freeze resume avail", {31'd0, mem_res_avail}, 32'd1);
        chk("freeze resume ram", {24'd0, ram[16'h0040]}, 32'h5A);
        is_io = 1'b0;
        is_store = 1'b0;
        @(negedge clk_in);

`ifdef MEM_IO_STALL_EN
        io_buffer_full = 1'b1;
        is_io = 1'b1;
        is_store = 1'b1;
        io_addr = 32'h0003_0000;
        io_data = 32'h0000_0077;
        io_op = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("io stall wr", {31'd0, mem_wr}, 32'd0);
            chk("io stall busy", {30'd0, mem_stuck, mem_res_avail}, 32'd2);
        end
        io_buffer_full = 1'b0;
        #1;
        chk("io stall release", {31'd0, mem_wr}, 32'd1);
        @(negedge clk_in);
        chk("io stall avail", {31'd0, mem_res_avail}, 32'd1);
        chk("io stall ram", {24'd0, ram[16'h0000]}, 32'h77);
        is_io = 1'b0;
        is_store = 1'b0;
        @(negedge clk_in);
`else
        io_buffer_full = 1'b1;
        do_store("io nostall", 32'h0003_0000, 3'b000, 1, 32'h0000_0077);
        chk("io nostall ram", {24'd0, ram[16'h0000]}, 32'h77);
        io_buffer_full = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
